// File: rtl/activation_unit.sv
// Two-stage multi-lane activation (ReLU / leaky ReLU / leaky derivative / passthrough)
// with valid/ready backpressure. Define ACTIVATION_UNIT_SAT_EN to saturate leaky products instead of wrapping.
module activation_unit #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES-1:0]          in_lane_en,
    input  logic [1:0]                in_mode,
    input  logic [DATA_W-1:0]         leak_factor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [DATA_W-1:0] ONE_C  = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;
    localparam logic [DATA_W-1:0] ZERO_C = {DATA_W{1'b0}};
`ifdef ACTIVATION_UNIT_SAT_EN
    localparam logic [DATA_W-1:0] MAX_C = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_C = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] MAX_EXT_C = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] MIN_EXT_C = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    logic                           adv_s;
    logic                           s1_valid_r;
    logic [LANES-1:0][DATA_W-1:0]   s1_data_r;
    logic [LANES-1:0][PROD_W-1:0]   s1_prod_r;
    logic [LANES-1:0]               s1_en_r;
    logic [1:0]                     s1_mode_r;
    logic [DATA_W-1:0]              s1_leak_r;
    logic [LANES*DATA_W-1:0]        res_s;

    function automatic logic signed [PROD_W-1:0] sext(input logic [DATA_W-1:0] v);
        return $signed({{DATA_W{v[DATA_W-1]}}, v});
    endfunction

    // Shift the Q-format product back to the lane format, then narrow to DATA_W.
    function automatic logic [DATA_W-1:0] narrow(input logic [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] sh;
        sh = $signed(prod) >>> FRAC_W;
`ifdef ACTIVATION_UNIT_SAT_EN
        if (sh > MAX_EXT_C) begin
            return MAX_C;
        end else if (sh < MIN_EXT_C) begin
            return MIN_C;
        end else begin
            return DATA_W'(sh);
        end
`else
        return DATA_W'(sh);
`endif
    endfunction

    function automatic logic [DATA_W-1:0] lane_act(
        input logic [DATA_W-1:0] x,
        input logic [PROD_W-1:0] prod,
        input logic [DATA_W-1:0] leak,
        input logic [1:0]        mode,
        input logic              en
    );
        logic pos;
        logic [DATA_W-1:0] r;
        pos = $signed(x) > $signed(ZERO_C);
        if (!en) begin
            r = ZERO_C;
        end else begin
            case (mode)
                2'd0:    r = pos ? x : ZERO_C;
                2'd1:    r = pos ? x : narrow(prod);
                2'd2:    r = pos ? ONE_C : leak;
                default: r = x;
            endcase
        end
        return r;
    endfunction

    assign adv_s    = !out_valid || out_ready;
    // Reset forces ready high so the upstream never sees a stalled handshake while both are in reset.
    assign in_ready = rst || adv_s;

    // Stage 1: capture the beat and its per-beat controls, form full-width products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_prod_r  <= '0;
            s1_en_r    <= '0;
            s1_mode_r  <= 2'd0;
            s1_leak_r  <= '0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            s1_en_r    <= in_lane_en;
            s1_mode_r  <= in_mode;
            s1_leak_r  <= leak_factor;
            for (int i = 0; i < LANES; i++) begin
                s1_data_r[i] <= in_data[i*DATA_W +: DATA_W];
                s1_prod_r[i] <= sext(in_data[i*DATA_W +: DATA_W]) * sext(leak_factor);
            end
        end
    end

    // Stage 2 result selection per lane.
    always_comb begin
        res_s = '0;
        for (int i = 0; i < LANES; i++) begin
            res_s[i*DATA_W +: DATA_W] = lane_act(s1_data_r[i], s1_prod_r[i], s1_leak_r,
                                                 s1_mode_r, s1_en_r[i]);
        end
    end

    // Stage 2 output register; a bubble clears the data word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv_s) begin
            out_valid <= s1_valid_r;
            out_data  <= s1_valid_r ? res_s : '0;
        end
    end

endmodule
